// File: rtl/seq_arith_pkg.sv
// Shared types for the sequential arithmetic unit: opcode and FSM state encodings.
// Also holds the helper that sizes the multiply iteration counter.
package seq_arith_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      MUL  = 2'b10,
      DONE = 2'b11
   } state_e;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/seq_arith_mul_core.sv
// Iterative shift-add unsigned multiplier; one partial product per cycle, WIDTH cycles fixed.
// product is valid combinationally in the cycle where done is high.
module seq_arith_mul_core
   import seq_arith_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [2*WIDTH-1:0] r_a_shift;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_b_shift;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic [2*WIDTH-1:0] w_acc_next;

   assign w_acc_next = r_b_shift[0] ? (r_acc + r_a_shift) : r_acc;
   assign done       = r_busy && (r_cnt == LAST);
   // The final partial product is folded in here so the top can capture it on the done edge.
   assign product    = w_acc_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_shift <= '0;
         r_b_shift <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
      end else if (start) begin
         r_a_shift <= {{WIDTH{1'b0}}, a};
         r_b_shift <= b;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b1;
      end else if (r_busy) begin
         r_acc     <= w_acc_next;
         r_a_shift <= r_a_shift << 1;
         r_b_shift <= r_b_shift >> 1;
         if (r_cnt == LAST) begin
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/seq_arith_unit.sv
// Multi-cycle add/sub/mul unit with valid/ready handshakes on operands and result.
// One operation in flight; the result is held in DONE until the consumer takes it.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for an operand pair
//   CALC  | single-cycle add/sub/reserved result into y
//   MUL   | shift-add multiply running in the mul core
//   DONE  | out_valid high, y/err held until out_ready
module seq_arith_unit
   import seq_arith_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   y,
   output logic                 err
);

   state_e             r_state;
   op_e                r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_y;
   logic               r_err;

   logic               w_accept;
   logic               w_mul_start;
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_product;
   logic [2*WIDTH-1:0] w_a_ext;
   logic [2*WIDTH-1:0] w_b_ext;

   assign in_ready    = (r_state == IDLE);
   assign out_valid   = (r_state == DONE);
   assign y           = r_y;
   assign err         = r_err;
   assign w_accept    = in_ready && in_valid;
   assign w_mul_start = w_accept && (op_e'(op) == OP_MUL);
   assign w_a_ext     = {{WIDTH{1'b0}}, r_a};
   assign w_b_ext     = {{WIDTH{1'b0}}, r_b};

   seq_arith_mul_core #(
      .WIDTH (WIDTH)
   ) u_mul_core (
      .clk     (clk),
      .rst     (rst),
      .start   (w_mul_start),
      .a       (a),
      .b       (b),
      .done    (w_mul_done),
      .product (w_product)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_op    <= OP_ADD;
         r_a     <= '0;
         r_b     <= '0;
         r_y     <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_op    <= op_e'(op);
                  r_err   <= 1'b0;
                  r_state <= (op_e'(op) == OP_MUL) ? MUL : CALC;
               end
            end
            CALC: begin
               case (r_op)
                  OP_ADD:  r_y <= w_a_ext + w_b_ext;
                  OP_SUB:  r_y <= w_a_ext - w_b_ext;
                  default: begin
                     r_y   <= '0;
                     r_err <= 1'b1;
                  end
               endcase
               r_state <= DONE;
            end
            MUL: begin
               if (w_mul_done) begin
                  r_y     <= w_product;
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed and random checks of seq_arith_unit at WIDTH=4 and WIDTH=8 against a scoreboard.
module tb_seq_arith_unit;
   import seq_arith_pkg::*;

   logic        clk;
   logic        rst;

   logic        iv4, ir4, ov4, or4, err4;
   logic [1:0]  op4;
   logic [3:0]  a4, b4;
   logic [7:0]  y4;

   logic        iv8, ir8, ov8, or8, err8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8;
   logic [15:0] y8;

   int checks   = 0;
   int failures = 0;

   logic [16:0] q4[$];
   logic [16:0] q8[$];

   seq_arith_unit #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op(op4), .a(a4), .b(b4),
      .out_valid(ov4), .out_ready(or4), .y(y4), .err(err4)
   );

   seq_arith_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op8), .a(a8), .b(b8),
      .out_valid(ov8), .out_ready(or8), .y(y8), .err(err8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference result: {err, y} with y zero-extended to 16 bits.
   function automatic logic [16:0] model(input int w, input logic [1:0] o, input int x, input int yy);
      int   r;
      int   mask;
      logic e;
      mask = (1 << (2 * w)) - 1;
      e    = 1'b0;
      case (o)
         2'd0:    r = x + yy;
         2'd1:    r = (x - yy) & mask;
         2'd2:    r = x * yy;
         default: begin r = 0; e = 1'b1; end
      endcase
      return {e, 16'(r)};
   endfunction

   task automatic accept4(input logic [1:0] o, input int x, input int yy);
      int n = 0;
      op4 = o; a4 = 4'(x); b4 = 4'(yy); iv4 = 1'b1;
      while (!ir4 && n < 100) begin @(posedge clk); #1; n++; end
      if (!ir4) chk("accept4_timeout", 32'(ir4), 1);
      @(posedge clk); #1;
      iv4 = 1'b0; op4 = 2'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      q4.push_back(model(4, o, x, yy));
   endtask

   task automatic wait_out4(output int k);
      k = 0;
      while (!ov4 && k < 100) begin @(posedge clk); #1; k++; end
      if (!ov4) chk("wait4_timeout", 32'(ov4), 1);
   endtask

   task automatic consume4(input string tag);
      logic [16:0] e;
      e = q4.pop_front();
      chk({tag, "_y"}, 32'(y4), 32'(e[7:0]));
      chk({tag, "_err"}, 32'(err4), 32'(e[16]));
      or4 = 1'b1;
      @(posedge clk); #1;
      or4 = 1'b0;
      chk({tag, "_ov_drop"}, 32'(ov4), 0);
      chk({tag, "_ready_back"}, 32'(ir4), 1);
   endtask

   task automatic take4();
      logic [16:0] e;
      int n = 0;
      bit got = 0;
      while (!got && n < 300) begin
         or4 = 1'($urandom_range(0, 1));
         if (ov4 && or4) begin
            e = q4.pop_front();
            chk("rand4_y", 32'(y4), 32'(e[7:0]));
            chk("rand4_err", 32'(err4), 32'(e[16]));
            got = 1;
         end
         @(posedge clk); #1;
         n++;
      end
      or4 = 1'b0;
      if (!got) chk("take4_timeout", 0, 1);
      chk("rand4_ov_drop", 32'(ov4), 0);
   endtask

   task automatic accept8(input logic [1:0] o, input int x, input int yy);
      int n = 0;
      op8 = o; a8 = 8'(x); b8 = 8'(yy); iv8 = 1'b1;
      while (!ir8 && n < 100) begin @(posedge clk); #1; n++; end
      if (!ir8) chk("accept8_timeout", 32'(ir8), 1);
      @(posedge clk); #1;
      iv8 = 1'b0; op8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      q8.push_back(model(8, o, x, yy));
   endtask

   task automatic take8();
      logic [16:0] e;
      int n = 0;
      bit got = 0;
      while (!got && n < 300) begin
         or8 = 1'($urandom_range(0, 1));
         if (ov8 && or8) begin
            e = q8.pop_front();
            chk("rand8_y", 32'(y8), 32'(e[15:0]));
            chk("rand8_err", 32'(err8), 32'(e[16]));
            got = 1;
         end
         @(posedge clk); #1;
         n++;
      end
      or8 = 1'b0;
      if (!got) chk("take8_timeout", 0, 1);
      chk("rand8_ov_drop", 32'(ov8), 0);
   endtask

   initial begin
      int k;
      logic [1:0] o;
      int x, yy;

      rst = 1'b1;
      iv4 = 1'b0; or4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
      iv8 = 1'b0; or8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      #12;
      chk("rst_in_ready4", 32'(ir4), 1);
      chk("rst_out_valid4", 32'(ov4), 0);
      chk("rst_y4", 32'(y4), 0);
      chk("rst_err4", 32'(err4), 0);
      chk("rst_in_ready8", 32'(ir8), 1);
      chk("rst_out_valid8", 32'(ov8), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // ADD, then the multiply latency cases
      accept4(OP_ADD, 3, 3);
      wait_out4(k);
      chk("add_latency", k + 1, 2);
      consume4("add_3_3");

      accept4(OP_MUL, 4, 5);
      wait_out4(k);
      chk("mul_latency", k + 1, 5);
      consume4("mul_4_5");

      accept4(OP_MUL, 15, 15);
      wait_out4(k);
      consume4("mul_15_15");

      accept4(OP_MUL, 0, 9);
      wait_out4(k);
      chk("mul_zero_latency", k + 1, 5);
      consume4("mul_0_9");

      accept4(OP_SUB, 2, 3);
      wait_out4(k);
      chk("sub_latency", k + 1, 2);
      consume4("sub_2_3");

      accept4(OP_RSVD, 5, 6);
      wait_out4(k);
      consume4("rsvd");

      accept4(OP_ADD, 1, 2);
      wait_out4(k);
      consume4("add_after_rsvd");

      // Back-pressure with ignored input pulses
      accept4(OP_MUL, 7, 3);
      wait_out4(k);
      for (int i = 0; i < 10; i++) begin
         iv4 = 1'(i % 2); op4 = OP_ADD; a4 = 4'd9; b4 = 4'd9;
         @(posedge clk); #1;
         chk("bp_out_valid", 32'(ov4), 1);
         chk("bp_y_stable", 32'(y4), 21);
         chk("bp_in_ready", 32'(ir4), 0);
      end
      iv4 = 1'b0;
      consume4("bp_mul_7_3");
      repeat (3) begin @(posedge clk); #1; end
      chk("bp_no_phantom", 32'(ov4), 0);
      chk("bp_idle", 32'(ir4), 1);

      // Asynchronous reset in the second MUL cycle
      accept4(OP_MUL, 6, 7);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(ov4), 0);
      chk("arst_y", 32'(y4), 0);
      chk("arst_in_ready", 32'(ir4), 1);
      q4.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      accept4(OP_ADD, 4, 5);
      wait_out4(k);
      consume4("add_after_rst");

      for (int i = 0; i < 1000; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom_range(0, 15);
         yy = $urandom_range(0, 15);
         accept4(o, x, yy);
         take4();
      end
      chk("q4_empty", q4.size(), 0);

      accept8(OP_MUL, 255, 255);
      take8();
      accept8(OP_SUB, 0, 1);
      take8();
      accept8(OP_ADD, 255, 255);
      take8();
      for (int i = 0; i < 1000; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom_range(0, 255);
         yy = $urandom_range(0, 255);
         accept8(o, x, yy);
         take8();
      end
      chk("q8_empty", q8.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_arith_unit.md
# seq_arith_unit

Parametrised multi-cycle arithmetic unit that accepts operand pairs over a valid/ready handshake, computes add, subtract or unsigned multiply, and returns a double-width result over a second valid/ready handshake. Multiply is an iterative shift-add taking WIDTH cycles; add and subtract complete in one cycle. The block sits between a stimulus or command source and a result consumer. It serves as the reusable, clocked, back-pressurable form of our operand-pair arithmetic.

## Interface

- WIDTH, 4, operand width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operand pair and op present
- in_ready  output  1  unit can accept; high only in IDLE
- op  input  2  00 ADD, 01 SUB, 10 MUL, 11 reserved
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- out_valid  output  1  result present; held until consumed
- out_ready  input  1  consumer accepts result
- y  output  2*WIDTH  result
- err  output  1  result slot was produced by reserved op; qualified by out_valid

## Operation

- States: IDLE, CALC, MUL, DONE.
- IDLE: in_ready=1. On in_valid: latch a, b, op.
  - Op ADD/SUB/11: go to CALC.
  - Op MUL: go to MUL, iteration counter = 0, accumulator = 0.
- CALC: compute the result into y register, then go to DONE.
  - ADD: y = zero-extended a + b (max 2^(WIDTH+1)-2).
  - SUB: y = (a − b) mod 2^(2*WIDTH), operands zero-extended first; e.g. WIDTH=4, 2−3 → 8'hFF.
  - 11: y = 0, err = 1.
- MUL: one iteration per cycle. If b_shift[0], add a_shift to the accumulator; then shift a_shift left and b_shift right.
  - After WIDTH iterations (counter == WIDTH−1 on the final cycle): y = accumulator, go to DONE.
  - No early termination on b = 0; the latency is fixed.
- DONE: out_valid=1. y and err are held stable while out_ready=0.
  - On out_ready: go to IDLE, out_valid drops the next cycle.
- in_valid while not in IDLE is ignored (in_ready=0); the source must hold its data.
- Operands are captured at acceptance. Later changes on a/b/op have no effect on an in-flight operation.
- err clears on the next acceptance.

## Timing

- Reset (async assert, any state): state=IDLE, in_ready=1, out_valid=0, y=0, err=0, counter=0, accumulator=0.
  - An in-flight operation or pending result is discarded.
  - Release is synchronous to the next rising edge.
- Latency, measured from the accept edge (in_valid&in_ready sampled high) to the first edge where out_valid is high:
  - ADD/SUB/reserved: 2 cycles (CALC, then DONE).
  - MUL: WIDTH+1 cycles (WIDTH MUL cycles, then DONE).
- Throughput:
  - One operation is in flight at most.
  - Minimum spacing between accepts is latency + 1 cycles (DONE→IDLE).
  - No accept occurs in the same cycle as result consumption.
- out_valid=1 with out_ready=0 stalls indefinitely, with no data change.
- out_ready while out_valid=0 has no effect.
- Counter width: $clog2(WIDTH) bits. The counter does not wrap mid-operation.
- Accumulator width: 2*WIDTH. It cannot overflow, since (2^W−1)^2 < 2^(2W).

## Structure

- Package seq_arith_pkg:
  - op_e enum (OP_ADD, OP_SUB, OP_MUL, OP_RSVD, 2 bits).
  - state_e enum (IDLE, CALC, MUL, DONE).
- Top-level seq_arith_unit holds the FSM, the handshake logic and the result/err registers.
- One sub-module, seq_arith_mul_core (parameter WIDTH):
  - Holds the shift registers, counter and accumulator.
  - Ports: start, a, b in; done, product out.
  - Reset on the same asynchronous rst.

## Test plan

- WIDTH=4, ADD a=3 b=3, out_ready=1 → y=6, err=0, out_valid 2 cycles after accept, in_ready back high the cycle after consume.
- WIDTH=4, MUL a=4 b=5 → y=20, out_valid exactly 5 cycles after accept. Then a=15 b=15 → y=225. Then a=0 b=9 → y=0, same 5-cycle latency.
- WIDTH=4, SUB a=2 b=3 → y=8'hFF. Then op=11 → y=0, err=1. Next ADD 1+2 → y=3, err=0.
- Back-pressure: MUL 7×3 with out_ready=0 for 10 cycles → out_valid stays 1, y=21 stable, in_ready=0. In-between in_valid pulses with a=9 b=9 are ignored.
- Reset during MUL (assert rst on the 2nd MUL cycle, asynchronously between edges) → out_valid=0, y=0, in_ready=1 immediately. The next ADD 4+5 → y=9.
- Random regression, WIDTH=4 and WIDTH=8, 1000 ops with random out_ready → every y matches the model; no result lost or duplicated.
